// File: rtl/ppu_pkg.sv
// ============================================================================
// Module      : ppu_pkg
// Description : Shared sizing helpers, default posit widths and the
//               round-to-nearest-even decision used by the rounding stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ppu_pkg;

    // Regime value spans -(n-2)..(n-2); one extra bit carries the sign.
    function automatic int calc_k_bits(input int n);
        return $clog2(n - 1) + 1;
    endfunction

    // Regime run length spans 2..n.
    function automatic int calc_reg_len_bits(input int n);
        return $clog2(n + 1);
    endfunction

    // Total exponent is k*2^es + e, plus headroom so saturation is visible.
    function automatic int calc_te_bits(input int n, input int es);
        return calc_k_bits(n) + es + 2;
    endfunction

    localparam int PPU_N        = 16;
    localparam int PPU_ES       = 1;
    localparam int MANT_SIZE    = 16;
    localparam int K_BITS       = calc_k_bits(PPU_N);
    localparam int REG_LEN_BITS = calc_reg_len_bits(PPU_N);
    localparam int TE_BITS      = calc_te_bits(PPU_N, PPU_ES);

    // RNE: round up on guard set unless it is an exact tie with an even LSB.
    function automatic logic round_rne(input logic kept_lsb,
                                       input logic guard,
                                       input logic sticky);
        return guard & (sticky | kept_lsb);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_ctrl.sv
// ============================================================================
// Module      : pipe_stage_ctrl
// Description : Valid/ready controller for one pipeline register stage.
//               The stage loads when empty or when its content drains.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_ctrl (
    input  logic clk,
    input  logic rst_n,
    input  logic up_valid,
    input  logic dn_ready,
    output logic valid,
    output logic load
);

    assign load = ~valid | dn_ready;

    // Stage occupancy follows the upstream valid whenever the stage loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= up_valid;
        end
    end

endmodule

`default_nettype wire

// File: rtl/posit_round_stage.sv
// ============================================================================
// Module      : posit_round_stage
// Description : Two-stage RNE rounding of an unrounded posit into the k/exp/
//               frac fields consumed by posit_encoder, with maxpos/minpos
//               saturation and a full-backpressure valid/ready handshake.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module posit_round_stage
    import ppu_pkg::*;
#(
    parameter  int N      = PPU_N,
    parameter  int ES     = PPU_ES,
    parameter  int MANT_W = MANT_SIZE,
    localparam int TE_W   = calc_te_bits(N, ES),
    localparam int K_W    = calc_k_bits(N)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   is_zero_i,
    input  logic                   is_nar_i,
    input  logic                   sign_i,
    input  logic signed [TE_W-1:0] te_i,
    input  logic [MANT_W-1:0]      mant_i,
    input  logic                   sticky_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   is_zero_o,
    output logic                   is_nar_o,
    output logic                   sign_o,
    output logic signed [K_W-1:0]  k_o,
    output logic [ES-1:0]          exp_o,
    output logic [MANT_W-1:0]      frac_o
);

    // Tail field is the exponent bits followed by the mantissa without its hidden 1.
    localparam int W    = ES + MANT_W - 1;
    localparam int SH_W = $clog2(W + 1);
    localparam int KMAX = N - 2;

    logic v1, v2, s1_load, s2_load;

    // Hidden bit is implied by normalisation and never enters the tail.
    logic unused_hidden;
    assign unused_hidden = mant_i[MANT_W-1];

    pipe_stage_ctrl u_ctrl_s1 (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .up_valid (valid_i),
        .dn_ready (s2_load),
        .valid    (v1),
        .load     (s1_load)
    );

    pipe_stage_ctrl u_ctrl_s2 (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .up_valid (v1),
        .dn_ready (ready_i),
        .valid    (v2),
        .load     (s2_load)
    );

    assign ready_o = s1_load;
    assign valid_o = v2;
    assign exp_o   = '0;

    // ---------------- Stage 1: field split, clamp and shift amount ----------
    int               k_int;
    int               reg_len;
    int               avail;
    logic             sat_d;
    logic [SH_W-1:0]  sh_d;
    logic [W-1:0]     f_d;
    logic [K_W-1:0]   k_d;
    logic             sign_d;

    logic [K_W-1:0]   s1_k;
    logic             s1_sat;
    logic [SH_W-1:0]  s1_sh;
    logic [W-1:0]     s1_f;
    logic             s1_sticky;
    logic             s1_nar;
    logic             s1_zero;
    logic             s1_sign;

    // Regime split, saturation clamp and the number of tail bits that fit.
    always_comb begin
        k_int  = int'(te_i >>> ES);
        sat_d  = 1'b0;
        if (k_int > KMAX) begin
            k_int = KMAX;
            sat_d = 1'b1;
        end else if (k_int < -KMAX) begin
            k_int = -KMAX;
            sat_d = 1'b1;
        end
        reg_len = (k_int >= 0) ? (k_int + 2) : (1 - k_int);
        avail   = N - 1 - reg_len;
        if (avail < 0) begin
            avail = 0;
        end
        sh_d   = SH_W'(W - avail);
        f_d    = {te_i[ES-1:0], mant_i[MANT_W-2:0]};
        k_d    = K_W'(k_int);
        sign_d = sign_i;
        if (is_nar_i | is_zero_i) begin
            k_d    = '0;
            sign_d = 1'b0;
        end
    end

    // Stage 1 register bank; NaR wins over zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_k      <= '0;
            s1_sat    <= 1'b0;
            s1_sh     <= '0;
            s1_f      <= '0;
            s1_sticky <= 1'b0;
            s1_nar    <= 1'b0;
            s1_zero   <= 1'b0;
            s1_sign   <= 1'b0;
        end else if (s1_load && valid_i) begin
            s1_k      <= k_d;
            s1_sat    <= sat_d;
            s1_sh     <= sh_d;
            s1_f      <= f_d;
            s1_sticky <= sticky_i;
            s1_nar    <= is_nar_i;
            s1_zero   <= is_zero_i & ~is_nar_i;
            s1_sign   <= sign_d;
        end
    end

    // ---------------- Stage 2: truncate and round ---------------------------
    logic [MANT_W-1:0] kept;
    logic              guard;
    logic [W-1:0]      st_mask;
    logic              st;
    logic              up;
    logic [MANT_W-1:0] frac_d;

    // Shift amount is at least ES+2, so guard and sticky positions always exist.
    always_comb begin
        kept    = MANT_W'(s1_f >> s1_sh);
        guard   = |(s1_f & (W'(1) << (s1_sh - 1'b1)));
        st_mask = (W'(1) << (s1_sh - 1'b1)) - W'(1);
        st      = (|(s1_f & st_mask)) | s1_sticky;
        up      = round_rne(kept[0], guard, st);
        // Rounding at the top regime would overflow maxpos into NaR.
        if ((s1_k == K_W'(KMAX)) || s1_sat || s1_nar || s1_zero) begin
            up = 1'b0;
        end
        // A carry out of the kept bits is left for the encoder to fold into the regime.
        frac_d = kept + MANT_W'(up);
        if (s1_sat || s1_nar || s1_zero) begin
            frac_d = '0;
        end
    end

    // Output register bank; holds while the downstream stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            k_o       <= '0;
            frac_o    <= '0;
            sign_o    <= 1'b0;
            is_nar_o  <= 1'b0;
            is_zero_o <= 1'b0;
        end else if (s2_load && v1) begin
            k_o       <= s1_k;
            frac_o    <= frac_d;
            sign_o    <= s1_sign;
            is_nar_o  <= s1_nar;
            is_zero_o <= s1_zero;
        end
    end

endmodule

`default_nettype wire

// File: doc/posit_round_stage.md
# posit_round_stage

Two-stage pipelined rounding stage that converts an unrounded posit (sign, total exponent, normalized mantissa, sticky) into the pre-encoded fields `k`, `exp` and `frac` that `posit_encoder` consumes. It computes round-to-nearest-even (RNE) on the true posit bit budget, and it saturates to maxpos/minpos. It sits between the PPU arithmetic core and `posit_encoder`, and uses a valid/ready handshake with full backpressure.

## Interface
- `N`, 16: posit width.
- `ES`, 1: exponent field width; requires `ES >= 1`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  upstream data valid.
- `ready_o`  out  1  stage can accept data.
- `is_zero_i`, `is_nar_i`  in  1  special-value flags.
- `sign_i`  in  1  sign of the result.
- `te_i`  in  TE_BITS  signed total exponent, equal to `k*2^ES + exp`.
- `mant_i`  in  MANT_SIZE  normalized mantissa; the MSB is the hidden 1.
- `sticky_i`  in  1  OR of all bits discarded upstream.
- `valid_o`  out  1  output valid.
- `ready_i`  in  1  downstream accepts.
- `is_zero_o`, `is_nar_o`, `sign_o`  out  1  fields forwarded to the encoder.
- `k_o`  out  K_BITS  regime value.
- `exp_o`  out  ES  exponent field; always 0 (see Operation).
- `frac_o`  out  MANT_SIZE  rounded tail, right-aligned.

## Operation
- Requires `MANT_SIZE >= N`.
- **Field split:** `k = te_i >>> ES` (arithmetic shift), `e = te_i[ES-1:0]`.
- **Saturation high:** if `k > N-2`, then `k_o = N-2` and `frac_o = 0` (maxpos).
- **Saturation low:** if `k < -(N-2)`, then `k_o = -(N-2)` and `frac_o = 0` (minpos).
- **Regime length and budget:** `reg_len = k>=0 ? k+2 : -k+1`. `avail = max(0, N-1-reg_len)`.
- **Tail field:** `F = {e, mant_i[MANT_SIZE-2:0]}`, width `W = ES+MANT_SIZE-1`. `sh = W - avail`.
- **Kept/dropped bits:** `kept = F >> sh`. Guard bit = `F[sh-1]`. Sticky = OR of `F[sh-2:0]` OR `sticky_i`.
- **RNE:** round up when `guard & (sticky | kept[0])`. Then `frac_o = kept + up`, width `avail+1`.
- **Carry handling:** a carry-out of `frac_o` is intentional. The encoder's additive packing propagates it into the regime.
- **Exponent port:** `exp_o` is always 0. The exponent bits travel inside `frac_o`, which covers the case where the regime truncates the exponent.
- **NaR guard:** if `k == N-2`, then `up` is forced to 0. This prevents rounding maxpos into NaR.
- **Special values:** `is_nar_i` takes priority over `is_zero_i`. If either is set, `k_o = 0` and `frac_o = 0`, the flag is forwarded, and `sign_o = 0`.
- **Pipeline split:**
  - S1 registers `k` (clamped), `sat`, `sh`, `F`, `sticky_i`, the flags and the sign.
  - S2 registers the shift and RNE result.

## Timing
- **Latency:** 2 cycles from an accepted `valid_i & ready_o` to `valid_o`.
- **Throughput:** 1 result per cycle.
- **Stage load conditions:**
  - S2 loads when `!v2 | ready_i`.
  - S1 loads when `!v1 | s2_load`.
  - `ready_o = !v1 | s2_load`. This is combinational from `ready_i`.
- **Output hold:** while `valid_o & !ready_i`, all outputs hold stable.
- **Ordering:** order is preserved. No drops or duplicates, including when `ready_i` toggles every cycle.
- **Simultaneous events:** an input accept and an output drain in the same cycle are legal when both stages are full.
- **Reset values:** asynchronous assert forces `v1 = v2 = 0`. All data registers reset to 0, so `valid_o`, `k_o`, `frac_o`, `exp_o`, `sign_o` and the flags are all 0.
- **Reset mid-operation:** in-flight data is discarded. `ready_o = 1` in the first cycle after deassert.

## Structure
- `ppu_pkg` gains `TE_BITS` and a function `round_rne(kept, guard, sticky)`.
- `ppu_pkg` reuses the existing `K_BITS`, `REG_LEN_BITS` and `MANT_SIZE`.
- One sub-module: `pipe_stage_ctrl`, the per-stage valid/ready register controller, instantiated twice.

## Test plan
All scenarios use N=8, ES=1, MANT_SIZE=8, feeding `posit_encoder`.
- `te=0`, `mant=0x80` -> `k_o=0`, `frac_o=0`, posit `0x40`. Then `mant=0xC0` -> `frac_o=8`, posit `0x48`.
- RNE, `te=0`: `mant=0x85` -> `frac_o=1`. `mant=0x84`, `sticky_i=0` -> `frac_o=0`. `mant=0x84`, `sticky_i=1` -> `frac_o=1`.
- Carry: `te=1`, `mant=0xFF` -> `k_o=0`, `frac_o=32`, posit `0x60` (4.0).
- Saturation: `te=20` -> `k_o=6`, `frac_o=0`, posit `0x7F`. `te=-20` -> `k_o=-6`, posit `0x01`. `te=13`, `mant=0xFF` -> no round-up, posit stays `0x7F`.
- Backpressure: 5 back-to-back inputs with `ready_i` low for cycles 2–5 -> `ready_o` falls once 2 entries are held, `valid_o` holds, and all 5 emerge in order.
- `rst_ni` pulsed low with 2 entries in flight -> `valid_o=0` immediately and all outputs 0. `is_nar_i` with `is_zero_i` -> `is_nar_o=1`, `is_zero_o=0`, after 2 cycles.
